// File: rtl/instruction_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Program feeder for the downstream processor. Issues stored
//               12-bit instructions with 8-bit immediates one at a time,
//               waits for proc_done, supports single-step and a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [11:0]       prog_code,
    input  logic [7:0]        prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              run,
    input  logic              step_mode,
    input  logic              proc_done,
    output logic [11:0]       machine_code,
    output logic [7:0]        dataIN,
    output logic              data_enable,
    output logic              start,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err
);

    localparam int         WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [2:0] C_LOAD_OP = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_PAUSE = 3'd5,
        S_DONE  = 3'd6,
        S_ERROR = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [11:0]       r_mem_code [DEPTH];
    logic [7:0]        r_mem_data [DEPTH];

    logic [11:0]       r_machine_code;
    logic [7:0]        r_data_in;
    logic              r_data_enable;
    logic [ADDR_W-1:0] r_pc;
    logic [WD_W-1:0]   r_watchdog;

    logic              w_busy;
    logic              w_last;
    logic              w_wd_expire;
    logic              w_addr_ok;

    // The DEPTH-1 term keeps pc from wrapping if prog_len exceeds DEPTH.
    assign w_last      = (({1'b0, r_pc} + (ADDR_W+1)'(1)) == prog_len)
                       || (r_pc == ADDR_W'(DEPTH - 1));
    assign w_wd_expire = (r_watchdog == WD_W'(TIMEOUT - 1));
    assign w_addr_ok   = ({1'b0, prog_addr} < (ADDR_W+1)'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        start        = 1'b0;
        halted       = 1'b0;
        timeout_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next_state = (prog_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                w_busy       = 1'b1;
                w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                w_busy       = 1'b1;
                start        = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (proc_done) begin
                    w_next_state = S_NEXT;
                end else if (w_wd_expire) begin
                    w_next_state = S_ERROR;
                end
            end
            S_NEXT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end else if (step_mode) begin
                    w_next_state = S_PAUSE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_PAUSE: begin
                w_busy = 1'b1;
                if (run) begin
                    w_next_state = S_FETCH;
                end
            end
            S_DONE: begin
                halted = 1'b1;
                if (run) begin
                    w_next_state = (prog_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_ERROR: begin
                timeout_err = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_machine_code <= '0;
            r_data_in      <= '0;
            r_data_enable  <= 1'b0;
            r_pc           <= '0;
            r_watchdog     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        r_pc <= '0;
                    end
                end
                S_FETCH: begin
                    r_machine_code <= r_mem_code[r_pc];
                    r_data_in      <= r_mem_data[r_pc];
                    r_data_enable  <= (r_mem_code[r_pc][11:9] == C_LOAD_OP);
                end
                S_ISSUE: begin
                    r_watchdog <= '0;
                end
                S_WAIT: begin
                    if (!proc_done && !w_wd_expire) begin
                        r_watchdog <= r_watchdog + WD_W'(1);
                    end
                end
                S_NEXT: begin
                    if (!w_last) begin
                        r_pc <= r_pc + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
            // Drop the load qualifier as soon as the run ends, normally or not.
            if (w_next_state == S_DONE || w_next_state == S_ERROR) begin
                r_data_enable <= 1'b0;
            end
        end
    end

    // Program memory survives reset; writes only land while the feeder is idle.
    always_ff @(posedge clock) begin
        if (prog_we && !w_busy && w_addr_ok) begin
            r_mem_code[prog_addr] <= prog_code;
            r_mem_data[prog_addr] <= prog_data;
        end
    end

    assign machine_code = r_machine_code;
    assign dataIN       = r_data_in;
    assign data_enable  = r_data_enable;
    assign pc           = r_pc;
    assign busy         = w_busy;

endmodule
`default_nettype wire

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Program feeder that sits directly upstream of the processor and drives its machine_code, dataIN, data_enable and start inputs.
- Holds a small writable program memory of 12-bit instructions, each paired with an 8-bit immediate.
- Issues instructions one at a time with a start pulse, waits for the processor's done, then advances.
- Supports free-run and single-step modes, plus a watchdog that flags a processor that never finishes.

Parameters:
DEPTH, 16, number of program entries
ADDR_W, 4, program address width (log2 DEPTH)
TIMEOUT, 20, max WAIT cycles for proc_done before error

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state except program memory
prog_we  in  1  program write strobe
prog_addr  in  ADDR_W  program write address
prog_code  in  12  instruction word written
prog_data  in  8  immediate written alongside
prog_len  in  ADDR_W+1  number of instructions to run (0..DEPTH)
run  in  1  start program from pc=0 when idle/halted; resume when paused
step_mode  in  1  1 = pause after every instruction
proc_done  in  1  processor completion from downstream
machine_code  out  12  instruction to processor, registered
dataIN  out  8  immediate to processor, registered
data_enable  out  1  high while the issued opcode (bits 11:9) is 3'b001 (LOAD)
start  out  1  one-cycle issue pulse
pc  out  ADDR_W  index of current instruction
busy  out  1  high in FETCH/ISSUE/WAIT/NEXT/PAUSE
halted  out  1  program completed
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values: machine_code=0, dataIN=0, data_enable=0, start=0, pc=0, busy=0, halted=0, timeout_err=0, state=IDLE, watchdog=0.
- Program memory is not reset.
- Memory writes: synchronous, take effect when prog_we=1 and busy=0; writes with busy=1 are ignored. prog_addr >= DEPTH is ignored.
- States and transitions:
  - IDLE, run=1: pc<=0, halted<=0. If prog_len=0, go to DONE without issuing; else go to FETCH.
  - FETCH (1 cycle): machine_code<=mem[pc].code, dataIN<=mem[pc].data, data_enable<=(code[11:9]==3'b001). Go to ISSUE.
  - ISSUE (1 cycle): start=1. Go to WAIT and clear the watchdog.
  - WAIT: start=0; machine_code, dataIN and data_enable stay held.
    - proc_done=1: go to NEXT.
    - Otherwise watchdog++. When the watchdog reaches TIMEOUT: go to ERROR.
  - NEXT (1 cycle):
    - If pc+1 == prog_len: go to DONE.
    - Else pc<=pc+1; go to PAUSE if step_mode=1, else FETCH.
  - PAUSE: hold outputs. run=1 goes to FETCH.
  - DONE: halted=1, busy=0, data_enable<=0. run=1 restarts as from IDLE.
  - ERROR: timeout_err=1, busy=0, data_enable<=0. Exited only by reset; run is ignored.
- Latency: run sampled at edge k → FETCH during cycle k+1, start=1 during cycle k+2. proc_done sampled at edge m in WAIT → next start at cycle m+3 (NEXT, FETCH, ISSUE) in free-run.
- proc_done is only observed in WAIT; a done in ISSUE/FETCH/NEXT/PAUSE is ignored.
- run while in FETCH/ISSUE/WAIT/NEXT is ignored.
- step_mode is sampled in NEXT only.
- pc never wraps: prog_len=DEPTH ends at pc=DEPTH-1 then DONE.
- Reset mid-operation: returns to IDLE on the next edge with the reset values above; memory contents are kept.

Test Plan:
- Free-run 4-instruction program: mem = {12'h240/8'h21, 12'h280/8'h01, 12'h64A/8'h00, 12'h84A/8'h00}, prog_len=4, processor model asserts done 3 cycles after start.
  → Exactly 4 start pulses in order 240, 280, 64A, 84A.
  → dataIN=21 with data_enable=1 on the first, data_enable=0 on the 3rd/4th.
  → halted=1, busy=0, pc=3.
- Latency check: run at edge 10 → start high cycle 12. done sampled at edge 16 → next start high cycle 19.
- Step mode: step_mode=1, same program.
  → After the first done, state PAUSE with pc=1 and no start.
  → Each run pulse issues exactly one instruction; halted after the 4th run.
- Watchdog: done held 0.
  → timeout_err=1 exactly TIMEOUT=20 cycles after entering WAIT; busy=0.
  → run ignored until reset, after which timeout_err=0.
- Boundaries:
  → prog_len=0 with run: halted=1 next cycle, no start pulse.
  → prog_we while busy: memory unchanged (read back by a subsequent run).
  → done pulsed during the ISSUE cycle only: no advance, watchdog runs.
- Reset mid-WAIT: all outputs return to reset values next edge. A subsequent run re-executes the unchanged program from pc=0.
